// File: rtl/adder_pkg.sv
// Shared helpers and types for the pipelined adder.
//   chunk_width    - bits resolved per pipeline stage
//   divides_evenly - configuration check used at elaboration
//   stage_ctrl_t   - per-stage control bits
// No ports (package).
package adder_pkg;

  // Bits of the carry chain handled by each stage.
  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // The stage count must split the operand width into equal chunks.
  function automatic bit divides_evenly(input int unsigned width,
                                        input int unsigned stages);
    return (stages != 0) && ((width % stages) == 0);
  endfunction

  // Per-stage register contents: valid (1 bit), carry (1 bit) and a CHUNK-bit
  // sum slice. The slice width depends on the instance, so it is declared in
  // adder_stage; only the fixed-width control bits are grouped here.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/adder_stage.sv
// One registered slice of the pipelined carry chain.
// Optional macro: PIPELINED_ADDER_OVERFLOW_EN adds o_ovf (signed overflow of
// this slice treated as the most significant one).
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous reset, active high
//   i_advance  - pipeline moves this cycle
//   i_valid    - incoming slot holds a real beat
//   i_a, i_b   - operand chunks
//   i_carry    - carry from the previous stage (or cin)
//   o_valid    - registered slot valid
//   o_sum      - registered sum chunk
//   o_carry    - registered carry out of this chunk
//   o_ovf      - registered carry-into-MSB XOR carry-out (macro only)
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_advance,
  input  logic             i_valid,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_carry,
  output logic             o_valid,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_carry
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             o_ovf
`endif
);

  logic [CHUNK:0] w_add;
  stage_ctrl_t    r_ctrl;
  logic [CHUNK-1:0] r_sum;

  assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_carry};

  // Valid follows the pipeline; data only loads for real beats so bubbles
  // leave the previous result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_sum  <= '0;
    end else if (i_advance) begin
      r_ctrl.valid <= i_valid;
      if (i_valid) begin
        r_ctrl.carry <= w_add[CHUNK];
        r_sum        <= w_add[CHUNK-1:0];
      end
    end
  end

  assign o_valid = r_ctrl.valid;
  assign o_carry = r_ctrl.carry;
  assign o_sum   = r_sum;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic w_carry_into_msb;
  logic r_ovf;

  // Sum MSB = a ^ b ^ carry-in at that bit, so the carry into it is recoverable.
  assign w_carry_into_msb = w_add[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (i_advance && i_valid) begin
      r_ovf <= w_carry_into_msb ^ w_add[CHUNK];
    end
  end

  assign o_ovf = r_ovf;
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: a + b + cin over STAGES register stages, with a
// valid/ready handshake on both sides and a single global stall.
// Optional macro: PIPELINED_ADDER_OVERFLOW_EN adds the ovf output.
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   in_valid, in_ready  - input handshake; in_ready depends only on output side
//   a, b, cin           - operands and carry-in
//   out_valid, out_ready- output handshake
//   sum, cout           - registered result and carry out of bit WIDTH-1
//   ovf                 - registered signed overflow (macro only)
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  if (!divides_evenly(WIDTH, STAGES)) begin : gen_cfg_err
    $error("pipelined_adder: STAGES must divide WIDTH exactly");
  end

  logic              w_advance;
  logic [STAGES-1:0] w_valid;
  logic [STAGES-1:0] w_carry;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic [STAGES-1:0] w_ovf;
`endif

  // Whole pipeline moves together; it only stops when a result is waiting
  // and the consumer refuses it.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    // Operand bits still to be added: chunks k..STAGES-1, chunk k at the LSB.
    localparam int unsigned VIEW_W = WIDTH - k * CHUNK;

    logic [VIEW_W-1:0]      w_a_view;
    logic [VIEW_W-1:0]      w_b_view;
    logic                   w_valid_in;
    logic                   w_carry_in;
    logic [CHUNK-1:0]       w_sum_chunk;
    logic [(k+1)*CHUNK-1:0] w_sum_asm;

    if (k == 0) begin : gen_first
      assign w_a_view   = a;
      assign w_b_view   = b;
      assign w_valid_in = in_valid;
      assign w_carry_in = cin;
      assign w_sum_asm  = w_sum_chunk;
    end else begin : gen_rest
      logic [k*CHUNK-1:0] r_sum_lo;

      assign w_a_view   = gen_stage[k-1].gen_skew.r_a_skew;
      assign w_b_view   = gen_stage[k-1].gen_skew.r_b_skew;
      assign w_valid_in = w_valid[k-1];
      assign w_carry_in = w_carry[k-1];

      // Lower sum chunks finished by earlier stages ride along with the beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum_lo <= '0;
        end else if (w_advance && w_valid_in) begin
          r_sum_lo <= gen_stage[k-1].w_sum_asm;
        end
      end

      assign w_sum_asm = {w_sum_chunk, r_sum_lo};
    end

    if (k < STAGES - 1) begin : gen_skew
      logic [VIEW_W-CHUNK-1:0] r_a_skew;
      logic [VIEW_W-CHUNK-1:0] r_b_skew;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_a_skew <= '0;
          r_b_skew <= '0;
        end else if (w_advance && w_valid_in) begin
          r_a_skew <= w_a_view[VIEW_W-1:CHUNK];
          r_b_skew <= w_b_view[VIEW_W-1:CHUNK];
        end
      end
    end

    adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .i_advance(w_advance),
      .i_valid  (w_valid_in),
      .i_a      (w_a_view[CHUNK-1:0]),
      .i_b      (w_b_view[CHUNK-1:0]),
      .i_carry  (w_carry_in),
      .o_valid  (w_valid[k]),
      .o_sum    (w_sum_chunk),
      .o_carry  (w_carry[k])
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      ,
      .o_ovf    (w_ovf[k])
`endif
    );
  end

  assign out_valid = w_valid[STAGES-1];
  assign sum       = gen_stage[STAGES-1].w_sum_asm;
  assign cout      = w_carry[STAGES-1];
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  assign ovf       = w_ovf[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
module tb_pipelined_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  pipelined_adder #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  int checks = 0;
  int errors = 0;
  int accepted = 0;     // beats the model accepted
  int dut_seen = 0;     // results the DUT handed over
  int dut_pending = 0;  // DUT accepts minus DUT results since last reset

  // Reference: S slots, each holding the full result of the beat in it.
  logic         m_v    [S];
  logic [W-1:0] m_sum  [S];
  logic         m_cout [S];
  logic         m_ovf  [S];

  task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < S; i++) begin
      m_v[i]    = 1'b0;
      m_sum[i]  = '0;
      m_cout[i] = 1'b0;
      m_ovf[i]  = 1'b0;
    end
  endfunction

  // One clock cycle: drive, compare outputs against the model, update model.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic c, input logic ordy,
                       input int exp_ready);
    logic       adv;
    logic [W:0] full;
    rst = r; in_valid = v; a = aa; b = bb; cin = c; out_ready = ordy;
    #1;
    adv = !m_v[S-1] || ordy;
    check("in_ready", {16'h0, in_ready}, {16'h0, adv});
    if (exp_ready >= 0) check("stall_ready", {16'h0, in_ready}, exp_ready[W:0]);
    check("out_valid", {16'h0, out_valid}, {16'h0, m_v[S-1]});
    check("sum", {1'b0, sum}, {1'b0, m_sum[S-1]});
    check("cout", {16'h0, cout}, {16'h0, m_cout[S-1]});
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    check("ovf", {16'h0, ovf}, {16'h0, m_ovf[S-1]});
`endif
    if (r) begin
      dut_pending = 0;
    end else begin
      if (out_valid && out_ready) begin dut_seen++; dut_pending--; end
      if (in_valid && in_ready) dut_pending++;
    end
    if (r) begin
      model_reset();
    end else if (adv) begin
      for (int i = S - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        if (m_v[i-1]) begin
          m_sum[i]  = m_sum[i-1];
          m_cout[i] = m_cout[i-1];
          m_ovf[i]  = m_ovf[i-1];
        end
      end
      m_v[0] = v;
      if (v) begin
        full      = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
        m_sum[0]  = full[W-1:0];
        m_cout[0] = full[W];
        m_ovf[0]  = (aa[W-1] == bb[W-1]) && (full[W-1] != aa[W-1]);
        accepted++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom), ordy, -1);
    end
  endtask

  logic [W-1:0] ra [8];
  logic [W-1:0] rb [8];
  logic         rc [8];
  int           base;
  int           seen_base;
  int           cyc;
  int           k;
  logic         ordy;
  logic         v;

  initial begin
    // Reset held two cycles with in_valid high.
    rst = 1'b1; in_valid = 1'b1; a = '1; b = '1; cin = 1'b1; out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1, 1);
    check("rst_out_valid", {16'h0, out_valid}, 17'h0);
    check("rst_sum", {1'b0, sum}, 17'h0);
    check("rst_cout", {16'h0, cout}, 17'h0);
    check("rst_in_ready", {16'h0, in_ready}, 17'h1);
    idle(4, 1'b1);

    // Latency: visible after the third edge following acceptance.
    cycle(1'b0, 1'b1, 16'h1234, 16'h0001, 1'b0, 1'b1, 1);
    idle(2, 1'b1);
    check("lat_early", {16'h0, out_valid}, 17'h0);
    idle(1, 1'b1);
    check("lat_valid", {16'h0, out_valid}, 17'h1);
    check("lat_sum", {1'b0, sum}, 17'h1235);
    check("lat_cout", {16'h0, cout}, 17'h0);

    // Full carry ripple and MSB wrap.
    cycle(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1, -1);
    cycle(1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, -1);
    idle(2, 1'b1);
    check("ripple_sum", {1'b0, sum}, 17'h0);
    check("ripple_cout", {16'h0, cout}, 17'h1);
    idle(1, 1'b1);
    check("wrap_valid", {16'h0, out_valid}, 17'h1);
    check("wrap_sum", {1'b0, sum}, 17'h0);
    check("wrap_cout", {16'h0, cout}, 17'h1);
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    check("wrap_ovf", {16'h0, ovf}, 17'h1);
`endif
    idle(4, 1'b1);

    // Eight back-to-back beats, consumer stalls in cycles 5..7.
    for (int i = 0; i < 8; i++) begin
      ra[i] = W'($urandom); rb[i] = W'($urandom); rc[i] = 1'($urandom);
    end
    base = accepted;
    seen_base = dut_seen;
    cyc = 0;
    while ((accepted - base) < 8 && cyc < 30) begin
      k = accepted - base;
      ordy = !(cyc >= 5 && cyc <= 7);
      cycle(1'b0, 1'b1, ra[k], rb[k], rc[k], ordy, ordy ? 1 : 0);
      cyc++;
    end
    check("stream_accepted", 17'(accepted - base), 17'd8);
    check("stream_cycles", 17'(cyc), 17'd11);
    idle(8, 1'b1);
    check("stream_results", 17'(dut_seen - seen_base), 17'd8);

    // Bubbles: valid 1,0,1,0 reappears three edges later.
    for (int j = 0; j < 8; j++) begin
      v = (j < 4) && ((j % 2) == 0);
      cycle(1'b0, v, W'($urandom), W'($urandom), 1'($urandom), 1'b1, -1);
      check("bubble_valid", {16'h0, out_valid}, {16'h0, (j == 3 || j == 5)});
    end
    idle(2, 1'b1);

    // Reset with three beats in flight.
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, -1);
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, -1);
    check("flush_valid", {16'h0, out_valid}, 17'h0);
    check("flush_ready", {16'h0, in_ready}, 17'h1);
    seen_base = dut_seen;
    cycle(1'b0, 1'b1, 16'd1, 16'd2, 1'b0, 1'b1, -1);
    idle(2, 1'b1);
    check("flush_gone", {16'h0, out_valid}, 17'h0);
    idle(1, 1'b1);
    check("post_rst_valid", {16'h0, out_valid}, 17'h1);
    check("post_rst_sum", {1'b0, sum}, 17'd3);
    check("flush_none_out", 17'(dut_seen - seen_base), 17'd0);

    // Random traffic with random back-pressure.
    for (int j = 0; j < 60; j++) begin
      cycle(1'b0, 1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), -1);
    end
    idle(8, 1'b1);
    check("drain_balance", 17'(dut_pending), 17'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's combinational half/full adders.
- Adds two WIDTH-bit operands plus carry-in over STAGES clock stages. Each stage resolves one CHUNK = WIDTH/STAGES slice of the carry chain.
- Valid/ready handshake on both sides, so the block drops into streaming datapaths. Accepts one operation per cycle when not stalled.

Parameters:
WIDTH, 16, operand and sum width in bits
STAGES, 4, pipeline depth; must divide WIDTH exactly (elaboration error otherwise); STAGES=1 is legal

Ports:
clk  input  1  single clock, rising-edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  a+b+cin modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state clears on the rising clk edge with rst=1.
- Reset values:
  - every stage valid bit = 0, so out_valid = 0
  - sum = 0, cout = 0, and all internal chunk/carry registers = 0
  - in_ready = 1 on the first cycle after reset
- Transfers: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready. in_ready = advance (purely combinational from out_valid/out_ready; no dependence on in_valid).
- When advance=0, all stage registers hold and out_valid/sum/cout stay stable. A result is never dropped or duplicated.
- Stage k (0..STAGES-1):
  - Adds chunk k of the operands plus the carry registered by stage k-1. Stage 0 uses cin.
  - Registers the partial sum chunk and the carry.
  - Operand chunks k+1..STAGES-1 are carried forward (skewed) unmodified.
  - Already-computed sum chunks are carried forward to the output.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (STAGES register stages, last stage drives outputs), provided no stall.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Bubbles: in_valid=0 while advancing inserts a bubble (stage valid 0). Bubbles propagate; out_valid=0 for that slot. Data on an invalid slot is don't-care, but the bench expects it to hold its previous value (registers enable only on valid).
- Wrap-around: sum is modulo 2^WIDTH. cout=1 exactly when a+b+cin >= 2^WIDTH.
- Simultaneous accept and consume in the same cycle is legal and the normal streaming case.
- rst asserted mid-operation discards all in-flight beats. The next cycle has out_valid=0 and in_ready=1.
- No combinational path from a/b/cin to sum/cout.

Optional Feature:
- Macro: PIPELINED_ADDER_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), registered alongside sum. ovf = two's-complement signed overflow = carry into MSB XOR cout. Reset value 0; held during stall.
- Not defined: port absent, no extra logic. All other behaviour is identical.

Decomposition:
- Package adder_pkg:
  - function chunk_width(WIDTH, STAGES)
  - a localparam-style check helper for divisibility
  - a stage_t notion (valid, carry, sum chunk) expressed as documented packed-field widths
- One sub-module, adder_stage: a CHUNK-bit registered adder slice with enable, valid in/out, carry in/out.
- pipelined_adder instantiates STAGES copies via generate and handles the operand skew and output assembly.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, cout=0, in_ready=1 after release; no beat emerges.
- Basic latency (WIDTH=16, STAGES=4), out_ready=1: a=16'h1234, b=16'h0001, cin=0 at cycle 0 -> out_valid=1 at cycle 3 with sum=16'h1235, cout=0.
- Full carry ripple: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. Then a=16'h8000, b=16'h8000, cin=0 -> sum=0, cout=1 (ovf=1 if macro defined).
- Streaming with back-pressure:
  - send 8 back-to-back random beats; hold out_ready=0 for cycles 5-7
  - in_ready=0 in exactly those cycles; outputs stable while stalled
  - all 8 results match the reference model in order, none lost or duplicated
- Bubbles: in_valid pattern 1,0,1,0 with out_ready=1 -> out_valid pattern 1,0,1,0 delayed by 3 cycles.
- Reset mid-flight: 3 beats in pipe, assert rst one cycle -> no result from those beats ever appears; new beat a=1, b=2 after reset yields sum=3 four cycles later.
